// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/
// writeback over a shared-memory, single-ALU datapath and decodes funct.
//
// state   | meaning
// --------+---------------------------------------------------------
// FETCH   | read instruction at PC, PC+4 into PC when memory is ready
// DECODE  | read registers, precompute branch target, dispatch on op
// MEMADR  | compute load/store address
// MEMRD   | read data memory at ALUOut, wait for mem_ready
// MEMWB   | write loaded data into rt
// MEMWR   | write B to memory at ALUOut, strobe held until mem_ready
// RTYPEEX | execute R-type ALU op selected by funct
// ALUWB   | write ALUOut into rd
// BEQ     | compare A-B, load branch target when zero
// ADDIEX  | A + sign-extended immediate
// ORIEX   | A | zero-extended immediate
// IMMWB   | write ALUOut into rt
// JUMP    | load jump target into PC
module mc_controller #(
   parameter bit WAIT_MEM = 1'b1,
   parameter int STATE_W  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pcen,
   output logic               iord,
   output logic               memwrite,
   output logic               irwrite,
   output logic               regdst,
   output logic               memtoreg,
   output logic               regwrite,
   output logic               alusrca,
   output logic [2:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic [2:0]         alucontrol,
   output logic               illegal,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_ALUWB   = 4'd7,
      S_BEQ     = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ORIEX   = 4'd10,
      S_IMMWB   = 4'd11,
      S_JUMP    = 4'd12
   } state_t;

   state_t st, nxt;
   logic   mr;
   logic   pcwrite;
   logic   branch;

   // With WAIT_MEM=0 the memory is assumed single-cycle.
   assign mr    = WAIT_MEM ? mem_ready : 1'b1;
   assign state = STATE_W'(st);

   // State register; reset forces FETCH asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) st <= S_FETCH;
      else        st <= nxt;
   end

   // Moore decode plus mem_ready-qualified strobes; reset blanks every output
   // combinationally so in-flight writes drop without waiting for an edge.
   always_comb begin
      nxt        = S_FETCH;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 3'b000;
      pcsrc      = 2'b00;
      alucontrol = 3'b010;
      illegal    = 1'b0;
      case (st)
         S_FETCH: begin
            alusrcb = 3'b001;
            irwrite = mr;
            pcwrite = mr;
            nxt     = mr ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alusrcb = 3'b011;
            case (op)
               6'b100011, 6'b101011: nxt = S_MEMADR;
               6'b000000:            nxt = S_RTYPEEX;
               6'b000100:            nxt = S_BEQ;
               6'b001000:            nxt = S_ADDIEX;
               6'b001101:            nxt = S_ORIEX;
               6'b000010:            nxt = S_JUMP;
               default: begin
                  illegal = 1'b1;
                  nxt     = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 3'b010;
            nxt     = (op == 6'b100011) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord = 1'b1;
            nxt  = mr ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
            nxt      = mr ? S_FETCH : S_MEMWR;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            nxt     = S_ALUWB;
            case (funct)
               6'b100000: alucontrol = 3'b010;
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               default: begin
                  illegal = 1'b1;
                  nxt     = S_FETCH;
               end
            endcase
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         S_BEQ: begin
            alusrca    = 1'b1;
            alucontrol = 3'b110;
            branch     = 1'b1;
            pcsrc      = 2'b01;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 3'b010;
            nxt     = S_IMMWB;
         end
         S_ORIEX: begin
            alusrca    = 1'b1;
            alusrcb    = 3'b100;
            alucontrol = 3'b001;
            nxt        = S_IMMWB;
         end
         S_IMMWB: begin
            regwrite = 1'b1;
         end
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: begin
            alucontrol = 3'b000;
         end
      endcase
      pcen = pcwrite | (branch & zero);
      if (!reset) begin
         pcen       = 1'b0;
         iord       = 1'b0;
         memwrite   = 1'b0;
         irwrite    = 1'b0;
         regdst     = 1'b0;
         memtoreg   = 1'b0;
         regwrite   = 1'b0;
         alusrca    = 1'b0;
         alusrcb    = 3'b000;
         pcsrc      = 2'b00;
         alucontrol = 3'b000;
         illegal    = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: expected output vectors are queued as each
// step is driven and popped for comparison at the falling edge.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal;
   logic [2:0] alusrcb, alucontrol;
   logic [1:0] pcsrc;
   logic [3:0] state;

   typedef struct packed {
      logic [3:0] state;
      logic       pcen;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [2:0] alusrcb;
      logic [1:0] pcsrc;
      logic [2:0] alucontrol;
      logic       illegal;
   } exp_t;

   exp_t q[$];
   exp_t obs;
   int   checks = 0;
   int   errors = 0;

   mc_controller #(.WAIT_MEM(1'b1), .STATE_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .memwrite(memwrite),
      .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
      .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
      .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   assign obs = '{state, pcen, iord, memwrite, irwrite, regdst, memtoreg,
                  regwrite, alusrca, alusrcb, pcsrc, alucontrol, illegal};

   // Expected Moore outputs of each state, straight from the state descriptions.
   function automatic exp_t ex(input int s);
      exp_t e = '0;
      e.state      = 4'(s);
      e.alucontrol = 3'b010;
      case (s)
         0:  e.alusrcb = 3'b001;
         1:  e.alusrcb = 3'b011;
         2:  begin e.alusrca = 1'b1; e.alusrcb = 3'b010; end
         3:  e.iord = 1'b1;
         4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
         5:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
         6:  e.alusrca = 1'b1;
         7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
         8:  begin e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; end
         9:  begin e.alusrca = 1'b1; e.alusrcb = 3'b010; end
         10: begin e.alusrca = 1'b1; e.alusrcb = 3'b100; e.alucontrol = 3'b001; end
         11: e.regwrite = 1'b1;
         12: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
         default: e = '0;
      endcase
      return e;
   endfunction

   function automatic exp_t fetch_rdy();
      exp_t e = ex(0);
      e.irwrite = 1'b1;
      e.pcen    = 1'b1;
      return e;
   endfunction

   task automatic compare(input string tag);
      exp_t want;
      want = q.pop_front();
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   // One clock cycle: queue expectation, compare at negedge, return just after posedge.
   task automatic chk(input string tag, input exp_t e);
      q.push_back(e);
      @(negedge clk);
      compare(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      logic [5:0] fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      logic [2:0] ac [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

      reset = 1'b0; mem_ready = 1'b0; op = '0; funct = '0; zero = 1'b0;
      for (int i = 0; i < 3; i++) chk("reset_hold", '0);

      reset = 1'b1;
      chk("fetch_wait0", ex(0));
      chk("fetch_wait1", ex(0));
      mem_ready = 1'b1;
      chk("fetch_ready", fetch_rdy());

      // lw with no wait states
      op = 6'b100011;
      chk("lw_decode", ex(1));
      chk("lw_memadr", ex(2));
      chk("lw_memrd", ex(3));
      chk("lw_memwb", ex(4));
      chk("lw_fetch", fetch_rdy());

      // sw with two wait cycles in MEMWR
      op = 6'b101011;
      chk("sw_decode", ex(1));
      chk("sw_memadr", ex(2));
      mem_ready = 1'b0;
      chk("sw_memwr_w0", ex(5));
      chk("sw_memwr_w1", ex(5));
      mem_ready = 1'b1;
      chk("sw_memwr_done", ex(5));
      chk("sw_fetch", fetch_rdy());

      // every legal R-type funct
      op = 6'b000000;
      for (int i = 0; i < 5; i++) begin
         funct = fn[i];
         chk("rt_decode", ex(1));
         e = ex(6); e.alucontrol = ac[i];
         chk("rt_exec", e);
         chk("rt_aluwb", ex(7));
         chk("rt_fetch", fetch_rdy());
      end

      // illegal funct: pulse, no writeback
      funct = 6'b000111;
      chk("rtbad_decode", ex(1));
      e = ex(6); e.illegal = 1'b1;
      chk("rtbad_exec", e);
      chk("rtbad_fetch", fetch_rdy());

      // beq taken and not taken
      op = 6'b000100; zero = 1'b1;
      chk("beq1_decode", ex(1));
      e = ex(8); e.pcen = 1'b1;
      chk("beq1_exec", e);
      chk("beq1_fetch", fetch_rdy());
      zero = 1'b0;
      chk("beq0_decode", ex(1));
      chk("beq0_exec", ex(8));
      chk("beq0_fetch", fetch_rdy());

      // addi, ori, j
      op = 6'b001000;
      chk("addi_decode", ex(1));
      chk("addi_exec", ex(9));
      chk("addi_wb", ex(11));
      chk("addi_fetch", fetch_rdy());
      op = 6'b001101;
      chk("ori_decode", ex(1));
      chk("ori_exec", ex(10));
      chk("ori_wb", ex(11));
      chk("ori_fetch", fetch_rdy());
      op = 6'b000010;
      chk("j_decode", ex(1));
      chk("j_jump", ex(12));
      chk("j_fetch", fetch_rdy());

      // asynchronous reset in the middle of a stalled store
      op = 6'b101011;
      chk("swr_decode", ex(1));
      chk("swr_memadr", ex(2));
      mem_ready = 1'b0;
      chk("swr_memwr", ex(5));
      #2 reset = 1'b0;
      #1;
      q.push_back('0);
      compare("swr_async_reset");
      @(posedge clk); #1;
      chk("swr_reset_hold", '0);
      reset = 1'b1; mem_ready = 1'b1;
      chk("swr_refetch", fetch_rdy());

      // unsupported opcode
      op = 6'b111111; mem_ready = 1'b0;
      e = ex(1); e.illegal = 1'b1;
      chk("badop_decode", e);
      chk("badop_fetch", ex(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
